lane_rr_merge: RTL and testbench

//   Merges NUM_LANES independent valid/ready input streams into one registered output stream.

---
 rtl/lane_rr_merge_pkg.sv | 43 ++++
 rtl/lane_rr_merge_skid.sv | 69 ++++++
 rtl/lane_rr_merge.sv | 173 +++++++++++++++++
 tb/tb_lane_rr_merge.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_rr_merge_pkg.sv
// lane_rr_merge_pkg
//   Shared types and helpers for the lane round-robin merger.
//   - DATA_W_DEF : default payload width
//   - beat_t     : one buffered beat {data, last} at the default width
//   - rr_next()  : rotate-priority first-set search used by the arbiter
//   Optional feature macro used by lane_rr_merge: LANE_RR_MERGE_PKT_LOCK_EN
package lane_rr_merge_pkg;

  localparam int DATA_W_DEF = 32;

  // Upper bound on lanes the arbiter helper can search.
  localparam int MAX_LANES = 32;
  localparam int RR_IDX_W  = 5;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  last;
  } beat_t;

  // Returns the first set bit of req at or after ptr, wrapping at n.
  // Returns 0 when req is empty; callers qualify the result with |req.
  function automatic logic [RR_IDX_W-1:0] rr_next(
    input logic [MAX_LANES-1:0] req,
    input logic [RR_IDX_W-1:0]  ptr,
    input int unsigned          n
  );
    logic [RR_IDX_W-1:0] pick;
    logic                found;
    int unsigned         idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < MAX_LANES; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= n) idx = idx - n;
      if ((off < n) && !found && req[idx[RR_IDX_W-1:0]]) begin
        pick  = idx[RR_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/lane_rr_merge_skid.sv
// lane_skid_buf
//   Two-entry FIFO of beats for one input lane. Head is always slot 0, so the
//   beat presented on head never changes until it is popped.
//   Ports:
//     clk, rst : clock, synchronous active-high reset (empties the buffer)
//     push,din : write a beat (ignored when already holding two)
//     pop      : remove the head beat (ignored when empty)
//     head     : oldest held beat
//     count    : number of held beats, 0..2
module lane_skid_buf
  import lane_rr_merge_pkg::*;
#(
  parameter type beat_type = beat_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  beat_type   din,
  input  logic       pop,
  output beat_type   head,
  output logic [1:0] count
);

  beat_type   slot_reg [2];
  logic [1:0] count_reg;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && (count_reg != 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload slots need no reset; count alone says what is valid.
  always_ff @(posedge clk) begin
    case ({do_push, do_pop})
      2'b10: begin
        if (count_reg == 2'd0) slot_reg[0] <= din;
        else                   slot_reg[1] <= din;
      end
      2'b01: begin
        slot_reg[0] <= slot_reg[1];
      end
      2'b11: begin
        if (count_reg == 2'd1) begin
          slot_reg[0] <= din;
        end else begin
          slot_reg[0] <= slot_reg[1];
          slot_reg[1] <= din;
        end
      end
      default: ;
    endcase
  end

  assign head  = slot_reg[0];
  assign count = count_reg;

endmodule

// File: rtl/lane_rr_merge.sv
// lane_rr_merge
//   Merges NUM_LANES valid/ready input streams into one registered output
//   stream. Each lane has a 2-entry skid buffer; a round-robin arbiter picks
//   the next lane whenever the output register can be loaded.
//   Optional feature: define LANE_RR_MERGE_PKT_LOCK_EN to keep the grant on
//   one lane from the first beat of a packet until its in_last beat.
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     in_valid/in_ready  : per-lane handshake
//     in_data            : lane i at [i*DATA_W +: DATA_W]
//     in_last            : end-of-packet marker (used only with the lock feature)
//     out_valid/out_ready: output handshake
//     out_data, out_lane : registered payload and its source lane
//     out_last           : registered last bit (0 when the lock feature is out)
module lane_rr_merge
  import lane_rr_merge_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  parameter  int DATA_W    = DATA_W_DEF,
  localparam int LANE_W    = $clog2(NUM_LANES > 1 ? NUM_LANES : 2)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_LANES-1:0]        in_valid,
  output logic [NUM_LANES-1:0]        in_ready,
  input  logic [NUM_LANES*DATA_W-1:0] in_data,
  input  logic [NUM_LANES-1:0]        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [LANE_W-1:0]           out_lane,
  output logic                        out_last
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } lane_beat_t;

  lane_beat_t             lane_din   [NUM_LANES];
  lane_beat_t             lane_head  [NUM_LANES];
  logic [1:0]             lane_count [NUM_LANES];
  logic [NUM_LANES-1:0]   push;
  logic [NUM_LANES-1:0]   pop;
  logic [NUM_LANES-1:0]   nonempty;
  logic [NUM_LANES-1:0]   req;

  logic                   loadable;
  logic                   any_req;
  logic                   load;
  logic [LANE_W-1:0]      winner;
  lane_beat_t             sel_beat;
  logic [LANE_W-1:0]      rr_ptr_reg;

  logic                   out_valid_reg;
  logic [DATA_W-1:0]      out_data_reg;
  logic [LANE_W-1:0]      out_lane_reg;
  logic                   out_last_reg;

  assign loadable = !out_valid_reg || out_ready;
  assign load     = loadable && any_req;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      // Ready comes only from the registered count, never from out_ready.
      assign in_ready[gi] = !rst && (lane_count[gi] != 2'd2);
      assign push[gi]     = in_valid[gi] && in_ready[gi];
      assign nonempty[gi] = (lane_count[gi] != 2'd0);
      assign pop[gi]      = load && (winner == LANE_W'(gi));

      assign lane_din[gi].data = in_data[gi*DATA_W +: DATA_W];
`ifdef LANE_RR_MERGE_PKT_LOCK_EN
      assign lane_din[gi].last = in_last[gi];
`else
      assign lane_din[gi].last = 1'b0;
`endif

      lane_skid_buf #(
        .beat_type (lane_beat_t)
      ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (push[gi]),
        .din   (lane_din[gi]),
        .pop   (pop[gi]),
        .head  (lane_head[gi]),
        .count (lane_count[gi])
      );
    end
  endgenerate

`ifdef LANE_RR_MERGE_PKT_LOCK_EN
  logic              lock_reg;
  logic [LANE_W-1:0] lock_lane_reg;

  // While locked only the owning lane may request; others simply wait.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_req
      assign req[gi] = nonempty[gi] && (!lock_reg || (lock_lane_reg == LANE_W'(gi)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_reg      <= 1'b0;
      lock_lane_reg <= '0;
    end else if (load) begin
      lock_reg      <= !sel_beat.last;
      lock_lane_reg <= winner;
    end
  end
`else
  assign req = nonempty;

  // Last bits are not carried in this build.
  logic unused_last;
  assign unused_last = ^{in_last, sel_beat.last};
`endif

  generate
    if (NUM_LANES > 1) begin : g_arb
      assign winner  = LANE_W'(rr_next(MAX_LANES'(req), RR_IDX_W'(rr_ptr_reg), NUM_LANES));
      assign any_req = |req;

      always_ff @(posedge clk) begin
        if (rst) begin
          rr_ptr_reg <= '0;
        end else if (load) begin
          rr_ptr_reg <= (winner == LANE_W'(NUM_LANES - 1)) ? '0 : winner + LANE_W'(1);
        end
      end
    end else begin : g_single
      assign winner     = '0;
      assign any_req    = req[0];
      assign rr_ptr_reg = '0;
    end
  endgenerate

  always_comb begin
    sel_beat = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (winner == LANE_W'(i)) sel_beat = lane_head[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_lane_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (loadable) begin
      if (any_req) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= sel_beat.data;
        out_lane_reg  <= winner;
`ifdef LANE_RR_MERGE_PKT_LOCK_EN
        out_last_reg  <= sel_beat.last;
`else
        out_last_reg  <= 1'b0;
`endif
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_lane  = out_lane_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_lane_rr_merge.sv
// tb_lane_rr_merge
//   Directed self-checking bench for lane_rr_merge (4 lanes, 32-bit data).
//   The packet-lock scenario is compiled in when LANE_RR_MERGE_PKT_LOCK_EN is defined.
module tb_lane_rr_merge;

  localparam int NL = 4;
  localparam int DW = 32;
  localparam int LW = 2;
`ifdef LANE_RR_MERGE_PKT_LOCK_EN
  localparam logic EXP_LAST = 1'b1;
`else
  localparam logic EXP_LAST = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NL-1:0]    in_valid;
  logic [NL-1:0]    in_ready;
  logic [NL*DW-1:0] in_data;
  logic [NL-1:0]    in_last;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [LW-1:0]    out_lane;
  logic             out_last;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mon_data [$];
  logic [LW-1:0] mon_lane [$];
  logic          mon_last [$];

  always #5 clk = ~clk;

  lane_rr_merge #(.NUM_LANES(NL), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last)
  );

  // Record every output handshake that the next rising edge will complete.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_data.push_back(out_data);
      mon_lane.push_back(out_lane);
      mon_last.push_back(out_last);
      $display("beat: lane=%0d data=%h last=%0b", out_lane, out_data, out_last);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic v, input logic [DW-1:0] d, input logic lst);
    in_valid[l]          = v;
    in_data[l*DW +: DW]  = d;
    in_last[l]           = lst;
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_lane.delete();
    mon_last.delete();
  endtask

  task automatic wait_beats(input int want, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (mon_data.size() >= want) break;
      step();
    end
    if (mon_data.size() >= want) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = '1;
    in_data   = '0;
    in_last   = '1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_lane !== 2'd0) begin n_bad++; $display("FAIL reset_out_lane: got %0d want 0", out_lane); end
    end
    rst      = 1'b0;
    in_valid = '0;
    #1;
    n_cmp++; if (in_ready !== 4'b1111) begin n_bad++; $display("FAIL release_in_ready: got %b want 1111", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL release_out_data: got %h want 0", out_data); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL release_out_last: got %b want 0", out_last); end
  endtask

  task automatic test_single_lane();
    bit ok;
    clear_mon();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_lane(2, 1'b1, 32'hA0 + DW'(k), 1'b1);
      #1;
      n_cmp++; if (in_ready[2] !== 1'b1) begin n_bad++; $display("FAIL single_in_ready k=%0d: got %b want 1", k, in_ready[2]); end
      step();
      if (k == 0) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_latency_early: got out_valid=%b want 0", out_valid); end
      end
      if (k == 1) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hA0 || out_lane !== 2'd2) begin
          n_bad++; $display("FAIL single_latency: got v=%b d=%h l=%0d want v=1 d=a0 l=2", out_valid, out_data, out_lane);
        end
      end
    end
    set_lane(2, 1'b0, 32'h0, 1'b1);
    wait_beats(8, 20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got %0d beats want 8", mon_data.size()); end
    for (int k = 0; k < 8 && k < mon_data.size(); k++) begin
      n_cmp++;
      if (mon_data[k] !== 32'hA0 + DW'(k) || mon_lane[k] !== 2'd2 || mon_last[k] !== EXP_LAST) begin
        n_bad++;
        $display("FAIL single_beat%0d: got d=%h l=%0d last=%b want d=%h l=2 last=%b",
                 k, mon_data[k], mon_lane[k], mon_last[k], 32'hA0 + DW'(k), EXP_LAST);
      end
    end
    repeat (3) step();
  endtask

  task automatic test_fairness();
    bit      ok;
    int      seq [NL];
    int      cnt [NL];
    logic [NL-1:0] acc;
    // Fresh reset so the round-robin pointer starts at lane 0.
    rst = 1'b1; in_valid = '0; step(); rst = 1'b0;
    clear_mon();
    out_ready = 1'b1;
    for (int l = 0; l < NL; l++) begin seq[l] = 0; cnt[l] = 0; end
    for (int c = 0; c < 20; c++) begin
      for (int l = 0; l < NL; l++) set_lane(l, 1'b1, DW'((l << 8) | seq[l]), 1'b1);
      #1;
      acc = in_valid & in_ready;
      step();
      for (int l = 0; l < NL; l++) if (acc[l]) seq[l]++;
    end
    in_valid = '0;
    wait_beats(16, 20, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL fair_timeout: got %0d beats want 16", mon_data.size()); end
    for (int k = 0; k < 16 && k < mon_data.size(); k++) begin
      n_cmp++;
      if (mon_lane[k] !== LW'(k % 4) || mon_data[k] !== DW'(((k % 4) << 8) | (k / 4))) begin
        n_bad++;
        $display("FAIL fair_beat%0d: got l=%0d d=%h want l=%0d d=%h",
                 k, mon_lane[k], mon_data[k], k % 4, ((k % 4) << 8) | (k / 4));
      end
      cnt[int'(mon_lane[k])]++;
    end
    for (int l = 0; l < NL; l++) begin
      n_cmp++; if (cnt[l] !== 4) begin n_bad++; $display("FAIL fair_share lane%0d: got %0d want 4", l, cnt[l]); end
    end
    repeat (30) step();
  endtask

  task automatic test_backpressure();
    bit            ok;
    int            seq;
    int            changes;
    bit            have;
    logic [DW-1:0] held;
    logic          a;
    clear_mon();
    out_ready = 1'b0;
    seq = 0; changes = 0; have = 1'b0; held = '0;
    for (int c = 0; c < 10; c++) begin
      set_lane(1, 1'b1, 32'hB0 + DW'(seq), 1'b1);
      #1;
      a = in_ready[1];
      step();
      if (a) seq++;
      if (out_valid) begin
        if (!have) begin held = out_data; have = 1'b1; end
        else if (out_data !== held) changes++;
      end
    end
    // One beat sits in the output register, two in the skid buffer.
    n_cmp++; if (seq !== 3) begin n_bad++; $display("FAIL bp_accepted: got %0d want 3", seq); end
    n_cmp++; if (in_ready[1] !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready[1]); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hB0) begin n_bad++; $display("FAIL bp_held: got v=%b d=%h want v=1 d=b0", out_valid, out_data); end
    n_cmp++; if (changes !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes want 0", changes); end
    out_ready = 1'b1;
    for (int c = 0; c < 30 && seq < 6; c++) begin
      set_lane(1, 1'b1, 32'hB0 + DW'(seq), 1'b1);
      #1;
      a = in_ready[1];
      step();
      if (a) seq++;
    end
    set_lane(1, 1'b0, 32'h0, 1'b1);
    wait_beats(6, 20, ok);
    repeat (5) step();
    n_cmp++; if (mon_data.size() !== 6) begin n_bad++; $display("FAIL bp_count: got %0d beats want 6", mon_data.size()); end
    for (int k = 0; k < 6 && k < mon_data.size(); k++) begin
      n_cmp++;
      if (mon_data[k] !== 32'hB0 + DW'(k) || mon_lane[k] !== 2'd1) begin
        n_bad++; $display("FAIL bp_beat%0d: got d=%h l=%0d want d=%h l=1", k, mon_data[k], mon_lane[k], 32'hB0 + DW'(k));
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mon();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_lane(1, 1'b1, 32'hE0 + DW'(c), 1'b1);
      step();
    end
    n_cmp++; if (out_valid !== 1'b1 || in_ready[1] !== 1'b0) begin
      n_bad++; $display("FAIL midrst_setup: got v=%b rdy1=%b want v=1 rdy1=0", out_valid, in_ready[1]);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 0000", in_ready); end
    rst = 1'b0;
    set_lane(1, 1'b0, 32'h0, 1'b1);
    #1;
    n_cmp++; if (in_ready !== 4'b1111) begin n_bad++; $display("FAIL midrst_empty: got %b want 1111", in_ready); end
    repeat (4) step();
    n_cmp++; if (mon_data.size() !== 0) begin n_bad++; $display("FAIL midrst_discard: got %0d beats want 0", mon_data.size()); end
    // Pointer would favour lane 3 had it not been reset to 0.
    set_lane(0, 1'b1, 32'hC0, 1'b1);
    set_lane(3, 1'b1, 32'hC3, 1'b1);
    step();
    set_lane(0, 1'b0, 32'h0, 1'b1);
    set_lane(3, 1'b0, 32'h0, 1'b1);
    wait_beats(2, 10, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL midrst_timeout: got %0d beats want 2", mon_data.size()); end
    if (mon_data.size() >= 2) begin
      n_cmp++; if (mon_lane[0] !== 2'd0 || mon_data[0] !== 32'hC0) begin n_bad++; $display("FAIL midrst_first: got l=%0d d=%h want l=0 d=c0", mon_lane[0], mon_data[0]); end
      n_cmp++; if (mon_lane[1] !== 2'd3 || mon_data[1] !== 32'hC3) begin n_bad++; $display("FAIL midrst_second: got l=%0d d=%h want l=3 d=c3", mon_lane[1], mon_data[1]); end
    end
    repeat (3) step();
  endtask

`ifdef LANE_RR_MERGE_PKT_LOCK_EN
  task automatic test_lock();
    bit            ok;
    int            idx;
    int            s3;
    logic          a3;
    logic [3:0]    v0;
    logic [DW-1:0] d0 [4];
    logic [3:0]    l0;
    v0 = 4'b1101; l0 = 4'b1000;
    d0[0] = 32'hF0; d0[1] = 32'h0; d0[2] = 32'hF1; d0[3] = 32'hF2;
    clear_mon();
    out_ready = 1'b1;
    s3 = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) set_lane(0, v0[c], d0[c], l0[c]);
      else       set_lane(0, 1'b0, 32'h0, 1'b1);
      set_lane(3, 1'b1, 32'hD0 + DW'(s3), 1'b1);
      #1;
      a3 = in_ready[3];
      step();
      if (a3) s3++;
    end
    in_valid = '0;
    wait_beats(8, 20, ok);
    repeat (10) step();
    idx = -1;
    for (int k = 0; k < mon_data.size(); k++) if (idx < 0 && mon_lane[k] == 2'd0) idx = k;
    n_cmp++; if (idx < 0 || idx + 3 >= mon_data.size()) begin
      n_bad++; $display("FAIL lock_found: got idx=%0d size=%0d want packet present", idx, mon_data.size());
    end else begin
      n_cmp++; if (mon_data[idx] !== 32'hF0 || mon_last[idx] !== 1'b0) begin n_bad++; $display("FAIL lock_b0: got d=%h last=%b want d=f0 last=0", mon_data[idx], mon_last[idx]); end
      n_cmp++; if (mon_lane[idx+1] !== 2'd0 || mon_data[idx+1] !== 32'hF1 || mon_last[idx+1] !== 1'b0) begin
        n_bad++; $display("FAIL lock_b1: got l=%0d d=%h last=%b want l=0 d=f1 last=0", mon_lane[idx+1], mon_data[idx+1], mon_last[idx+1]);
      end
      n_cmp++; if (mon_lane[idx+2] !== 2'd0 || mon_data[idx+2] !== 32'hF2 || mon_last[idx+2] !== 1'b1) begin
        n_bad++; $display("FAIL lock_b2: got l=%0d d=%h last=%b want l=0 d=f2 last=1", mon_lane[idx+2], mon_data[idx+2], mon_last[idx+2]);
      end
      n_cmp++; if (mon_lane[idx+3] !== 2'd3) begin n_bad++; $display("FAIL lock_next: got l=%0d want 3", mon_lane[idx+3]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_lane();
    test_fairness();
    test_backpressure();
    test_reset_mid();
`ifdef LANE_RR_MERGE_PKT_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
